// File: rtl/gpca_op_sequencer.sv
// Sequential front-end for the combinational gpca array: accepts one command,
// drives the array's X/P/B/C/A encoding, waits a settle time, returns F/S.
module gpca_op_sequencer #(
  parameter int SETTLE_CYCLES = 4,
  parameter int CNT_W         = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [9:0]  cmd_a,
  input  logic [2:0]  cmd_b,
  output logic        gpca_x,
  output logic [4:0]  gpca_p,
  output logic [6:0]  gpca_b,
  output logic [6:0]  gpca_c,
  output logic [9:0]  gpca_a,
  input  logic [4:0]  gpca_f,
  input  logic [10:0] gpca_s,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [1:0]  rsp_op,
  output logic [4:0]  rsp_f,
  output logic [10:0] rsp_s,
  output logic        busy,
  output logic [1:0]  state_dbg
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are
  // both high; the sender holds its payload stable until that edge.

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [6:0]       SQ_B     = 7'b0011111;
  localparam logic [6:0]       SQ_C     = 7'b0100000;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             accept;
  logic             capture;
  logic             rsp_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)   state_nxt = SETTLE;
      SETTLE:  if (capture)  state_nxt = RESP;
      RESP:    if (rsp_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (state == IDLE);
    busy      = (state != IDLE);
    state_dbg = state;
    accept    = cmd_valid && (state == IDLE);
    capture   = (state == SETTLE) && (cnt == '0);
    rsp_done  = (state == RESP) && rsp_valid && rsp_ready;
  end

  // Array operands are loaded only on accept and hold until the next one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      gpca_x <= 1'b0;
      gpca_p <= '0;
      gpca_b <= '0;
      gpca_c <= '0;
      gpca_a <= '0;
      rsp_op <= '0;
    end else if (accept) begin
      cnt    <= CNT_LOAD;
      rsp_op <= cmd_op;
      case (cmd_op)
        2'b00: begin
          gpca_x <= 1'b0;
          gpca_p <= cmd_a[4:0];
          gpca_a <= '0;
          gpca_b <= {cmd_b, 4'b0000};
          gpca_c <= {cmd_b, 4'b0000};
        end
        2'b01: begin
          gpca_x <= 1'b0;
          gpca_p <= cmd_a[4:0];
          gpca_a <= '0;
          gpca_b <= SQ_B;
          gpca_c <= SQ_C;
        end
        2'b10: begin
          gpca_x <= 1'b1;
          gpca_p <= '0;
          gpca_a <= cmd_a;
          gpca_b <= SQ_B;
          gpca_c <= SQ_C;
        end
        default: begin
          gpca_x <= 1'b1;
          gpca_p <= '0;
          gpca_a <= {cmd_a[5:0], 4'b0000};
          gpca_b <= {cmd_b, 4'b0000};
          gpca_c <= {cmd_b, 4'b0000};
        end
      endcase
    end else if ((state == SETTLE) && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  // Response payload is captured once and then frozen until the next capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_f     <= '0;
      rsp_s     <= '0;
    end else if (capture) begin
      rsp_valid <= 1'b1;
      rsp_f     <= gpca_f;
      rsp_s     <= gpca_s;
    end else if (rsp_done) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_gpca_op_sequencer.sv
// Bench for gpca_op_sequencer: a stub array, a scoreboard fed by the command
// driver, and a monitor that checks handshakes, latency and held responses.
module tb_gpca_op_sequencer;

  localparam int SETTLE = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, rsp_valid, rsp_ready, busy;
  logic [1:0]  cmd_op, rsp_op, state_dbg;
  logic [9:0]  cmd_a, gpca_a;
  logic [2:0]  cmd_b;
  logic        gpca_x;
  logic [4:0]  gpca_p, gpca_f, rsp_f;
  logic [6:0]  gpca_b, gpca_c;
  logic [10:0] gpca_s, rsp_s;
  logic [15:0] noise;
  logic [29:0] enc_out;

  logic        cmd_valid_1, cmd_ready_1, rsp_valid_1, rsp_ready_1, busy_1;
  logic [1:0]  cmd_op_1, rsp_op_1, state_dbg_1;
  logic [9:0]  cmd_a_1, gpca_a_1;
  logic [2:0]  cmd_b_1;
  logic        gpca_x_1;
  logic [4:0]  gpca_p_1, gpca_f_1, rsp_f_1;
  logic [6:0]  gpca_b_1, gpca_c_1;
  logic [10:0] gpca_s_1, rsp_s_1;
  logic [29:0] enc_out_1;

  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          rr_mode = 0;
  bit          outstanding = 1'b0;
  bit          prev_valid = 1'b0;
  logic [17:0] held;
  logic [47:0] exp_q[$];
  int          acc_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Stub array: an arbitrary mix of every input bit so each operand field matters.
  function automatic logic [15:0] stub(input logic [29:0] e);
    logic       x;
    logic [4:0] p, f;
    logic [6:0] b, c;
    logic [9:0] a;
    logic [10:0] s;
    {x, p, b, c, a} = e;
    f = p ^ a[4:0] ^ a[9:5] ^ b[6:2] ^ {c[3:0], x};
    s = ({x, a} + {c, 4'b0000}) ^ {4'b0000, b} ^ {6'b000000, p};
    return {f, s};
  endfunction

  function automatic logic [29:0] enc(input logic [1:0] op, input logic [9:0] a,
                                      input logic [2:0] b);
    case (op)
      2'd0:    return {1'b0, a[4:0], {b, 4'b0000}, {b, 4'b0000}, 10'd0};
      2'd1:    return {1'b0, a[4:0], 7'b0011111, 7'b0100000, 10'd0};
      2'd2:    return {1'b1, 5'd0, 7'b0011111, 7'b0100000, a};
      default: return {1'b1, 5'd0, {b, 4'b0000}, {b, 4'b0000}, {a[5:0], 4'b0000}};
    endcase
  endfunction

  function automatic logic [47:0] model(input logic [1:0] op, input logic [9:0] a,
                                        input logic [2:0] b);
    logic [29:0] e;
    e = enc(op, a, b);
    return {op, stub(e), e};
  endfunction

  assign enc_out   = {gpca_x, gpca_p, gpca_b, gpca_c, gpca_a};
  assign {gpca_f, gpca_s} = stub(enc_out) ^ noise;
  assign enc_out_1 = {gpca_x_1, gpca_p_1, gpca_b_1, gpca_c_1, gpca_a_1};
  assign {gpca_f_1, gpca_s_1} = stub(enc_out_1);

  gpca_op_sequencer #(.SETTLE_CYCLES(SETTLE), .CNT_W(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .gpca_x(gpca_x), .gpca_p(gpca_p), .gpca_b(gpca_b), .gpca_c(gpca_c), .gpca_a(gpca_a),
    .gpca_f(gpca_f), .gpca_s(gpca_s), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_op(rsp_op), .rsp_f(rsp_f), .rsp_s(rsp_s), .busy(busy), .state_dbg(state_dbg)
  );

  gpca_op_sequencer #(.SETTLE_CYCLES(1), .CNT_W(4)) u_dut_1 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid_1), .cmd_ready(cmd_ready_1),
    .cmd_op(cmd_op_1), .cmd_a(cmd_a_1), .cmd_b(cmd_b_1),
    .gpca_x(gpca_x_1), .gpca_p(gpca_p_1), .gpca_b(gpca_b_1), .gpca_c(gpca_c_1),
    .gpca_a(gpca_a_1), .gpca_f(gpca_f_1), .gpca_s(gpca_s_1), .rsp_valid(rsp_valid_1),
    .rsp_ready(rsp_ready_1), .rsp_op(rsp_op_1), .rsp_f(rsp_f_1), .rsp_s(rsp_s_1),
    .busy(busy_1), .state_dbg(state_dbg_1)
  );

  task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Consumer side: rsp_ready changes just after each rising edge.
  always begin
    @(posedge clk);
    #1;
    case (rr_mode)
      0:       rsp_ready = 1'b1;
      1:       rsp_ready = 1'($urandom_range(0, 1));
      default: rsp_ready = 1'b0;
    endcase
  end

  // Monitor: samples on the falling edge, between driver updates.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("cmd_ready", {47'd0, cmd_ready}, {47'd0, !outstanding});
      chk("busy", {47'd0, busy}, {47'd0, outstanding});
      if (rsp_valid && !prev_valid) begin
        if (acc_q.size() == 0 || exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL rsp_unexpected: got rsp_valid=1 expected 0 (t=%0t)", $time);
        end else begin
          chk("latency", 48'(cyc - acc_q.pop_front()), 48'(SETTLE));
          chk("rsp", {rsp_op, rsp_f, rsp_s, enc_out}, exp_q[0]);
        end
        held = {rsp_op, rsp_f, rsp_s};
      end else if (rsp_valid) begin
        chk("rsp_hold", {30'd0, rsp_op, rsp_f, rsp_s}, {30'd0, held});
      end
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        outstanding = 1'b0;
      end
      if (cmd_valid && cmd_ready) begin
        outstanding = 1'b1;
        acc_q.push_back(cyc + 1);
      end
      prev_valid = rsp_valid;
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [1:0] op, input logic [9:0] a, input logic [2:0] b);
    int n = 0;
    cmd_op = op;
    cmd_a = a;
    cmd_b = b;
    cmd_valid = 1'b1;
    while (!cmd_ready && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("cmd_ready_wait", {47'd0, cmd_ready}, 48'd1);
    if (cmd_ready) exp_q.push_back(model(op, a, b));
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_op = 2'($urandom);
    cmd_a = 10'($urandom);
    cmd_b = 3'($urandom);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || exp_q.size() != 0) && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain", 48'(exp_q.size()), 48'd0);
  endtask

  task automatic chk_reset_zero(input string name);
    chk({name, "_gpca"}, {18'd0, enc_out}, 48'd0);
    chk({name, "_rsp"}, {29'd0, rsp_valid, rsp_op, rsp_f, rsp_s}, 48'd0);
  endtask

  task automatic back_to_back();
    logic [47:0] m1, m2;
    m1 = model(2'd0, 10'd3, 3'd2);
    m2 = model(2'd2, 10'd100, 3'd0);
    rsp_ready_1 = 1'b1;
    cmd_op_1 = 2'd0;
    cmd_a_1 = 10'd3;
    cmd_b_1 = 3'd2;
    cmd_valid_1 = 1'b1;
    chk("b2b_ready0", {47'd0, cmd_ready_1}, 48'd1);
    @(posedge clk); #1;
    chk("b2b_busy", {47'd0, cmd_ready_1}, 48'd0);
    chk("b2b_enc1", {18'd0, enc_out_1}, {18'd0, m1[29:0]});
    cmd_op_1 = 2'd2;
    cmd_a_1 = 10'd100;
    cmd_b_1 = 3'($urandom);
    @(posedge clk); #1;
    chk("b2b_rsp1_valid", {47'd0, rsp_valid_1}, 48'd1);
    chk("b2b_rsp1", {30'd0, rsp_op_1, rsp_f_1, rsp_s_1}, {30'd0, m1[47:30]});
    chk("b2b_ready_resp", {47'd0, cmd_ready_1}, 48'd0);
    @(posedge clk); #1;
    chk("b2b_rsp_clear", {47'd0, rsp_valid_1}, 48'd0);
    chk("b2b_ready_after", {47'd0, cmd_ready_1}, 48'd1);
    chk("b2b_enc_hold", {18'd0, enc_out_1}, {18'd0, m1[29:0]});
    chk("b2b_rsp_keep", {30'd0, rsp_op_1, rsp_f_1, rsp_s_1}, {30'd0, m1[47:30]});
    @(posedge clk); #1;
    chk("b2b_accept2", {47'd0, cmd_ready_1}, 48'd0);
    chk("b2b_enc2", {18'd0, enc_out_1}, {18'd0, m2[29:0]});
    cmd_valid_1 = 1'b0;
    @(posedge clk); #1;
    chk("b2b_rsp2_valid", {47'd0, rsp_valid_1}, 48'd1);
    chk("b2b_rsp2", {30'd0, rsp_op_1, rsp_f_1, rsp_s_1}, {30'd0, m2[47:30]});
    @(posedge clk); #1;
    chk("b2b_done", {47'd0, rsp_valid_1}, 48'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n = 1'b0;
    noise = '0;
    rsp_ready = 1'b1;
    cmd_valid = 1'b0;
    cmd_op = '0;
    cmd_a = '0;
    cmd_b = '0;
    cmd_valid_1 = 1'b0;
    cmd_op_1 = '0;
    cmd_a_1 = '0;
    cmd_b_1 = '0;
    rsp_ready_1 = 1'b0;
    #3;
    chk_reset_zero("reset");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("reset_ready", {46'd0, cmd_ready, busy}, 48'd2);

    // Directed operations with literal array encodings.
    send(2'd0, 10'd5, 3'd7);
    chk("mul_enc", {18'd0, enc_out}, {18'd0, 1'b0, 5'b00101, 7'b1110000, 7'b1110000, 10'd0});
    send(2'd1, 10'd5, 3'd6);
    chk("sqr_enc", {18'd0, enc_out}, {18'd0, 1'b0, 5'b00101, 7'b0011111, 7'b0100000, 10'd0});
    send(2'd2, 10'd25, 3'd1);
    chk("sqrt_enc", {18'd0, enc_out},
        {18'd0, 1'b1, 5'd0, 7'b0011111, 7'b0100000, 10'b0000011001});
    send(2'd3, 10'd35, 3'd5);
    chk("div_enc", {18'd0, enc_out},
        {18'd0, 1'b1, 5'd0, 7'b1010000, 7'b1010000, 10'b1000110000});
    wait_idle();

    // Backpressure: response frozen while the array outputs wander.
    rr_mode = 2;
    send(2'd3, 10'd17, 3'd3);
    n = 0;
    while (!rsp_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("bp_valid", {47'd0, rsp_valid}, 48'd1);
    repeat (10) begin
      @(posedge clk); #1;
      noise = 16'($urandom);
    end
    chk("bp_ready_low", {47'd0, cmd_ready}, 48'd0);
    rr_mode = 0;
    @(posedge clk); #1;
    noise = '0;
    @(posedge clk); #1;
    chk("bp_release", {46'd0, rsp_valid, cmd_ready}, 48'd1);

    // Reset in the middle of the settle window drops the command.
    send(2'd1, 10'd9, 3'd0);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk_reset_zero("mid_reset");
    exp_q.delete();
    acc_q.delete();
    outstanding = 1'b0;
    prev_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    chk("mid_reset_after", {45'd0, cmd_ready, busy, rsp_valid}, 48'd4);
    repeat (8) @(posedge clk);
    #1;

    // Randomized traffic with random gaps and random consumer stalls.
    rr_mode = 1;
    for (int i = 0; i < 40; i++) begin
      send(2'($urandom), 10'($urandom), 3'($urandom));
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end
    rr_mode = 0;
    wait_idle();

    back_to_back();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
